// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite controller: bounces the sprite position, steps the animation frame and
// publishes all outputs together at the end of each vertical-blank sequence.
module sprite_motion_ctrl #(
    parameter int X_BITS      = 10,
    parameter int Y_BITS      = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SPRITE_W    = 272,
    parameter int SPRITE_H    = 176,
    parameter int FRAMES_LOG2 = 1,
    parameter int RESET_X     = 128,
    parameter int RESET_Y     = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [2:0]             cfg_addr,
    input  logic [15:0]            cfg_data,
    output logic [X_BITS-1:0]      sprite_x,
    output logic [Y_BITS-1:0]      sprite_y,
    output logic [FRAMES_LOG2-1:0] anim_frame,
    output logic                   sprite_en,
    output logic                   overrun
);
    // state  | meaning
    // IDLE   | wait for frame_start; config writes accepted into shadow regs
    // COMMIT | shadow -> active copy; pending position overrides loaded (clamped)
    // MOVE_X | horizontal bounce step
    // MOVE_Y | vertical bounce step
    // ANIM   | animation tick; outputs published on the edge leaving this state
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COMMIT = 3'd1,
        S_MOVE_X = 3'd2,
        S_MOVE_Y = 3'd3,
        S_ANIM   = 3'd4
    } state_t;

    localparam logic [X_BITS:0] MAX_X = (X_BITS+1)'(SCREEN_W - SPRITE_W);
    localparam logic [Y_BITS:0] MAX_Y = (Y_BITS+1)'(SCREEN_H - SPRITE_H);

    state_t                 state_q, state_d;
    logic [2:0]             sh_ctrl_q, sh_ctrl_d, ctrl_q, ctrl_d;
    logic [4:0]             sh_period_q, sh_period_d, period_q, period_d;
    logic [3:0]             sh_dx_q, sh_dx_d, dx_q, dx_d;
    logic [3:0]             sh_dy_q, sh_dy_d, dy_q, dy_d;
    logic [X_BITS-1:0]      sh_pos_x_q, sh_pos_x_d, x_q, x_d, sprite_x_q, sprite_x_d;
    logic [Y_BITS-1:0]      sh_pos_y_q, sh_pos_y_d, y_q, y_d, sprite_y_q, sprite_y_d;
    logic                   pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic                   ovr_x_q, ovr_x_d, ovr_y_q, ovr_y_d;
    logic                   dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [4:0]             tick_q, tick_d;
    logic [FRAMES_LOG2-1:0] frame_q, frame_d;
    logic                   sprite_en_q, sprite_en_d;
    logic                   overrun_q, overrun_d;

    logic [X_BITS:0] x_sum;
    logic [Y_BITS:0] y_sum;
    logic [5:0]      tick_inc;
    logic            cfg_data_unused;

    // Widened sums so a step near the top of the range cannot wrap.
    assign x_sum           = {1'b0, x_q} + (X_BITS+1)'(dx_q);
    assign y_sum           = {1'b0, y_q} + (Y_BITS+1)'(dy_q);
    assign tick_inc        = {1'b0, tick_q} + 6'd1;
    assign cfg_data_unused = ^cfg_data[15:12];

    assign cfg_ready  = (state_q == S_IDLE);
    assign sprite_x   = sprite_x_q;
    assign sprite_y   = sprite_y_q;
    assign anim_frame = frame_q;
    assign sprite_en  = sprite_en_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d     = state_q;
        sh_ctrl_d   = sh_ctrl_q;
        sh_period_d = sh_period_q;
        sh_dx_d     = sh_dx_q;
        sh_dy_d     = sh_dy_q;
        sh_pos_x_d  = sh_pos_x_q;
        sh_pos_y_d  = sh_pos_y_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        ctrl_d      = ctrl_q;
        period_d    = period_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        ovr_x_d     = ovr_x_q;
        ovr_y_d     = ovr_y_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        tick_d      = tick_q;
        frame_d     = frame_q;
        sprite_x_d  = sprite_x_q;
        sprite_y_d  = sprite_y_q;
        sprite_en_d = sprite_en_q;
        overrun_d   = overrun_q;

        if (frame_start && (state_q != S_IDLE)) overrun_d = 1'b1;

        if (cfg_valid && cfg_ready) begin
            case (cfg_addr)
                3'd0: sh_ctrl_d   = cfg_data[2:0];
                3'd1: sh_period_d = cfg_data[4:0];
                3'd2: begin
                    sh_dx_d = cfg_data[3:0];
                    sh_dy_d = cfg_data[11:8];
                end
                3'd3: begin
                    sh_pos_x_d = cfg_data[X_BITS-1:0];
                    pend_x_d   = 1'b1;
                end
                3'd4: begin
                    sh_pos_y_d = cfg_data[Y_BITS-1:0];
                    pend_y_d   = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: if (frame_start) state_d = S_COMMIT;
            S_COMMIT: begin
                state_d  = S_MOVE_X;
                ctrl_d   = sh_ctrl_q;
                period_d = sh_period_q;
                dx_d     = sh_dx_q;
                dy_d     = sh_dy_q;
                ovr_x_d  = pend_x_q;
                ovr_y_d  = pend_y_q;
                if (pend_x_q) begin
                    x_d      = ({1'b0, sh_pos_x_q} > MAX_X) ? MAX_X[X_BITS-1:0] : sh_pos_x_q;
                    pend_x_d = 1'b0;
                end
                if (pend_y_q) begin
                    y_d      = ({1'b0, sh_pos_y_q} > MAX_Y) ? MAX_Y[Y_BITS-1:0] : sh_pos_y_q;
                    pend_y_d = 1'b0;
                end
            end
            S_MOVE_X: begin
                state_d = S_MOVE_Y;
                if (ctrl_q[2] && !ovr_x_q) begin
                    if (!dir_x_q) begin
                        if (x_sum >= MAX_X) begin
                            x_d     = MAX_X[X_BITS-1:0];
                            dir_x_d = 1'b1;
                        end else begin
                            x_d = x_sum[X_BITS-1:0];
                        end
                    end else if (x_q <= X_BITS'(dx_q)) begin
                        x_d     = '0;
                        dir_x_d = 1'b0;
                    end else begin
                        x_d = x_q - X_BITS'(dx_q);
                    end
                end
            end
            S_MOVE_Y: begin
                state_d = S_ANIM;
                if (ctrl_q[2] && !ovr_y_q) begin
                    if (!dir_y_q) begin
                        if (y_sum >= MAX_Y) begin
                            y_d     = MAX_Y[Y_BITS-1:0];
                            dir_y_d = 1'b1;
                        end else begin
                            y_d = y_sum[Y_BITS-1:0];
                        end
                    end else if (y_q <= Y_BITS'(dy_q)) begin
                        y_d     = '0;
                        dir_y_d = 1'b0;
                    end else begin
                        y_d = y_q - Y_BITS'(dy_q);
                    end
                end
            end
            S_ANIM: begin
                state_d     = S_IDLE;
                sprite_x_d  = x_q;
                sprite_y_d  = y_q;
                sprite_en_d = ctrl_q[0];
                if (ctrl_q[1] && (period_q != 5'd0)) begin
                    if (tick_inc == {1'b0, period_q}) begin
                        tick_d  = 5'd0;
                        frame_d = frame_q + FRAMES_LOG2'(1);
                    end else begin
                        tick_d = tick_inc[4:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sh_ctrl_q   <= 3'b011;
            sh_period_q <= 5'd16;
            sh_dx_q     <= 4'd0;
            sh_dy_q     <= 4'd0;
            sh_pos_x_q  <= '0;
            sh_pos_y_q  <= '0;
            pend_x_q    <= 1'b0;
            pend_y_q    <= 1'b0;
            ctrl_q      <= 3'b011;
            period_q    <= 5'd16;
            dx_q        <= 4'd0;
            dy_q        <= 4'd0;
            ovr_x_q     <= 1'b0;
            ovr_y_q     <= 1'b0;
            x_q         <= X_BITS'(RESET_X);
            y_q         <= Y_BITS'(RESET_Y);
            dir_x_q     <= 1'b0;
            dir_y_q     <= 1'b0;
            tick_q      <= 5'd0;
            frame_q     <= '0;
            sprite_x_q  <= X_BITS'(RESET_X);
            sprite_y_q  <= Y_BITS'(RESET_Y);
            sprite_en_q <= 1'b1;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_ctrl_q   <= sh_ctrl_d;
            sh_period_q <= sh_period_d;
            sh_dx_q     <= sh_dx_d;
            sh_dy_q     <= sh_dy_d;
            sh_pos_x_q  <= sh_pos_x_d;
            sh_pos_y_q  <= sh_pos_y_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            ctrl_q      <= ctrl_d;
            period_q    <= period_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            ovr_x_q     <= ovr_x_d;
            ovr_y_q     <= ovr_y_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            tick_q      <= tick_d;
            frame_q     <= frame_d;
            sprite_x_q  <= sprite_x_d;
            sprite_y_q  <= sprite_y_d;
            sprite_en_q <= sprite_en_d;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: constant vector table, hand-written corner sequences and
// randomized frames checked against an arithmetic model of the frame rules.
module tb_sprite_motion_ctrl;
    localparam int XB = 10;
    localparam int YB = 10;
    localparam int FL = 1;
    localparam int MAXX = 640 - 272;
    localparam int MAXY = 480 - 176;

    logic          clk = 1'b0;
    logic          rst_n, frame_start, cfg_valid, cfg_ready;
    logic [2:0]    cfg_addr;
    logic [15:0]   cfg_data;
    logic [XB-1:0] sprite_x;
    logic [YB-1:0] sprite_y;
    logic [FL-1:0] anim_frame;
    logic          sprite_en, overrun;

    sprite_motion_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .anim_frame(anim_frame),
        .sprite_en(sprite_en), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    int sh_ctrl, sh_period, sh_dx, sh_dy, sh_px, sh_py;
    int a_ctrl, a_period, a_dx, a_dy;
    bit pend_x, pend_y;
    int m_x, m_y, m_dirx, m_diry, m_tick, m_frame, m_ovr;
    int o_x, o_y, o_en, o_frame;

    typedef struct {
        bit         wr;
        logic [2:0] addr;
        logic [15:0] data;
        int         exp_x;
        int         exp_y;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        sh_ctrl = 3; sh_period = 16; sh_dx = 0; sh_dy = 0; sh_px = 0; sh_py = 0;
        a_ctrl = 3; a_period = 16; a_dx = 0; a_dy = 0;
        pend_x = 0; pend_y = 0;
        m_x = 128; m_y = 128; m_dirx = 1; m_diry = 1; m_tick = 0; m_frame = 0; m_ovr = 0;
        o_x = 128; o_y = 128; o_en = 1; o_frame = 0;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [15:0] d);
        int v;
        v = int'(d);
        case (a)
            3'd0: sh_ctrl = v & 7;
            3'd1: sh_period = v & 31;
            3'd2: begin sh_dx = v & 15; sh_dy = (v >> 8) & 15; end
            3'd3: begin sh_px = v % (1 << XB); pend_x = 1; end
            3'd4: begin sh_py = v % (1 << YB); pend_y = 1; end
            default: ;
        endcase
    endtask

    task automatic step_axis(input int p, input int dir, input int d, input int mx,
                             output int np, output int nd);
        np = p; nd = dir;
        if (dir > 0) begin
            if (p + d >= mx) begin np = mx; nd = -1; end
            else np = p + d;
        end else begin
            if (p <= d) begin np = 0; nd = 1; end
            else np = p - d;
        end
    endtask

    task automatic model_frame();
        bit ovx, ovy;
        int np, nd;
        a_ctrl = sh_ctrl; a_period = sh_period; a_dx = sh_dx; a_dy = sh_dy;
        ovx = pend_x; ovy = pend_y;
        if (pend_x) begin m_x = (sh_px > MAXX) ? MAXX : sh_px; pend_x = 0; end
        if (pend_y) begin m_y = (sh_py > MAXY) ? MAXY : sh_py; pend_y = 0; end
        if ((a_ctrl & 4) != 0 && !ovx) begin
            step_axis(m_x, m_dirx, a_dx, MAXX, np, nd); m_x = np; m_dirx = nd;
        end
        if ((a_ctrl & 4) != 0 && !ovy) begin
            step_axis(m_y, m_diry, a_dy, MAXY, np, nd); m_y = np; m_diry = nd;
        end
        if ((a_ctrl & 2) != 0 && a_period != 0) begin
            if (m_tick + 1 == a_period) begin
                m_tick = 0;
                m_frame = (m_frame + 1) % (1 << FL);
            end else begin
                m_tick = (m_tick + 1) % 32;
            end
        end
        o_x = m_x; o_y = m_y; o_en = a_ctrl & 1; o_frame = m_frame;
    endtask

    // Called at a negedge while the DUT is idle.
    task automatic do_write(input logic [2:0] a, input logic [15:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_valid = 1'b0;
        model_write(a, d);
    endtask

    // One frame sequence starting at a negedge in IDLE. Optional write alongside frame_start,
    // optional held write during the busy cycles, optional second pulse at T+2, optional reset at T+3.
    task automatic run_frame(input bit wr, input logic [2:0] a, input logic [15:0] d,
                             input bit hold, input logic [15:0] d2,
                             input bit dbl, input bit abort);
        int busy, px, pf;
        busy = 0;
        px = o_x; pf = o_frame;
        frame_start = 1'b1;
        if (wr) begin
            cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
            model_write(a, d);
        end
        @(negedge clk);
        frame_start = 1'b0;
        if (hold) cfg_data = d2;
        else cfg_valid = 1'b0;
        model_frame();
        if (dbl) m_ovr = 1;
        for (int i = 1; i <= 4; i++) begin
            if (!cfg_ready) busy++;
            if (i == 2 && dbl) frame_start = 1'b1;
            if (i == 3) frame_start = 1'b0;
            if (i == 3 && abort) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
                check("abort_x", int'(sprite_x), 128);
                check("abort_y", int'(sprite_y), 128);
                check("abort_frame", int'(anim_frame), 0);
                check("abort_en", int'(sprite_en), 1);
                check("abort_ready", int'(cfg_ready), 1);
                check("abort_overrun", int'(overrun), 0);
                return;
            end
            if (i == 4) begin
                check("atomic_x", int'(sprite_x), px);
                check("atomic_frame", int'(anim_frame), pf);
            end
            @(negedge clk);
        end
        check("busy_cycles", busy, 4);
        check("ready_T5", int'(cfg_ready), 1);
        check("x", int'(sprite_x), o_x);
        check("y", int'(sprite_y), o_y);
        check("anim_frame", int'(anim_frame), o_frame);
        check("sprite_en", int'(sprite_en), o_en);
        check("overrun", int'(overrun), m_ovr);
        if (hold) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            model_write(a, d2);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd0, 16'h0007, 128, 128};
        vecs[1]  = '{1'b1, 3'd2, 16'h0F0F, 143, 143};
        vecs[2]  = '{1'b1, 3'd4, 16'd290,  158, 290};
        vecs[3]  = '{1'b1, 3'd3, 16'd350,  350, 304};
        vecs[4]  = '{1'b0, 3'd0, 16'd0,    365, 289};
        vecs[5]  = '{1'b0, 3'd0, 16'd0,    368, 274};
        vecs[6]  = '{1'b0, 3'd0, 16'd0,    353, 259};
        vecs[7]  = '{1'b1, 3'd3, 16'd1000, 368, 244};
        vecs[8]  = '{1'b0, 3'd0, 16'd0,    353, 229};
        vecs[9]  = '{1'b1, 3'd3, 16'd5,    5,   214};
        vecs[10] = '{1'b0, 3'd0, 16'd0,    0,   199};
        vecs[11] = '{1'b0, 3'd0, 16'd0,    15,  184};

        rst_n = 1'b0; frame_start = 1'b0; cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_data = 16'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_x", int'(sprite_x), 128);
        check("rst_y", int'(sprite_y), 128);
        check("rst_frame", int'(anim_frame), 0);
        check("rst_en", int'(sprite_en), 1);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_overrun", int'(overrun), 0);

        for (int p = 1; p <= 16; p++) begin
            run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
            if (p == 15) check("anim_p15", int'(anim_frame), 0);
            if (p == 16) check("anim_p16", int'(anim_frame), 1);
            check("static_x", int'(sprite_x), 128);
        end

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
            check($sformatf("vec%0d_x", i), int'(sprite_x), vecs[i].exp_x);
            check($sformatf("vec%0d_y", i), int'(sprite_y), vecs[i].exp_y);
        end

        run_frame(1'b1, 3'd2, 16'h0305, 1'b1, 16'h0101, 1'b0, 1'b0);
        check("same_cycle_wr_x", int'(sprite_x), 20);
        check("same_cycle_wr_y", int'(sprite_y), 181);
        run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        check("held_wr_x", int'(sprite_x), 21);
        check("held_wr_y", int'(sprite_y), 180);

        run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0);
        check("overrun_set", int'(overrun), 1);
        check("overrun_frame_x", int'(sprite_x), 22);
        run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        check("overrun_sticky", int'(overrun), 1);

        do_write(3'd0, 16'h0000);
        do_write(3'd2, 16'h0F0F);
        run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b1);
        run_frame(1'b0, 3'd0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
        check("post_rst_x", int'(sprite_x), 128);
        check("post_rst_en", int'(sprite_en), 1);

        for (int f = 0; f < 40; f++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++)
                do_write(3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
            run_frame(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      16'($urandom_range(0, 65535)), 1'b0, 16'd0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sprite_motion_ctrl.md
# sprite_motion_ctrl

Per-frame controller for the sprite renderer. Once per video frame it sequences the sprite's position, bounce direction and animation-frame index, and drives these to the pixel datapath as a single atomic update during vertical blank. A small register-write port configures it. Writes land in shadow registers and take effect only at a frame boundary, so the picture never tears mid-frame.

## Interface
Parameters:
- X_BITS, 10, width of sprite_x
- Y_BITS, 10, width of sprite_y
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 272, scaled sprite width
- SPRITE_H, 176, scaled sprite height
- FRAMES_LOG2, 1, log2 of the animation frame count
- RESET_X, 128, sprite_x after reset
- RESET_Y, 128, sprite_y after reset

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- frame_start  in  1  one-cycle pulse at the start of vertical blank, from the timing generator
- cfg_valid  in  1  write request
- cfg_ready  out  1  write can be accepted
- cfg_addr  in  3  0=CTRL, 1=PERIOD, 2=VEL, 3=POS_X, 4=POS_Y; 5-7 accepted and ignored
- cfg_data  in  16  write data
- sprite_x  out  X_BITS  sprite left edge
- sprite_y  out  Y_BITS  sprite top edge
- anim_frame  out  FRAMES_LOG2  bitmap frame select
- sprite_en  out  1  draw sprite
- overrun  out  1  sticky: frame_start arrived while the controller was not IDLE

## Operation
Register fields:
- CTRL[0] enable (reset 1)
- CTRL[1] anim_run (reset 1)
- CTRL[2] move_en (reset 0)
- PERIOD[4:0]: frames per animation step (reset 16); 0 freezes the animation
- VEL[3:0]: dx, VEL[11:8]: dy; both unsigned step magnitudes (reset 0)
- POS_X / POS_Y: low bits are the position override. A write sets a pending flag for that axis.

Write handshake:
- A write is accepted when cfg_valid && cfg_ready.
- Accepted data lands in the shadow register at the next edge.
- cfg_ready = (state == IDLE).

State machine, IDLE→COMMIT→MOVE_X→MOVE_Y→ANIM→IDLE:
- **IDLE:** wait for frame_start.
- **COMMIT:** copy shadow CTRL/PERIOD/VEL to the active registers.
  - For each axis with a pending override, load the position clamped to max and clear the flag.
  - max_x = SCREEN_W−SPRITE_W (368); max_y = SCREEN_H−SPRITE_H (304).
- **MOVE_X:** applies only if move_en is set and the axis was not overridden this frame.
  - Direction +: if x+dx ≥ max_x, set x=max_x and flip direction to −; else x+=dx.
  - Direction −: if x ≤ dx, set x=0 and flip direction to +; else x−=dx.
  - Compute one bit wider than X_BITS so no overflow occurs.
- **MOVE_Y:** same rule using dy and max_y.
- **ANIM:** applies if anim_run is set and PERIOD≠0.
  - tick+1 == PERIOD: tick=0 and anim_frame+=1, wrapping modulo 2^FRAMES_LOG2.
  - Otherwise tick+=1.
  - If anim_run=0, tick and anim_frame hold.
- Direction bits reset to +. They persist across frames and are not altered by overrides.

## Timing
- frame_start sampled high in IDLE at cycle T: state is COMMIT at T+1, MOVE_X at T+2, MOVE_Y at T+3, ANIM at T+4, IDLE at T+5.
- Working values are internal. sprite_x, sprite_y, anim_frame and sprite_en are all registered and update together on the edge ending ANIM, so they are visible from T+5.
- cfg_ready is low T+1..T+4.
- A write accepted at cycle T is included in that frame's COMMIT.
- frame_start while not IDLE: ignored and sets overrun, which clears only on reset.
- Reset values:
  - sprite_x=RESET_X, sprite_y=RESET_Y
  - anim_frame=0, tick=0
  - sprite_en=1, cfg_ready=1, overrun=0
  - pending flags cleared
- Reset mid-sequence returns to IDLE the next edge; shadow writes are discarded.

## Test plan
- Reset, then 16 frame_start pulses → anim_frame 0→1 at pulse 16 (T+5); x/y stay 128/128; cfg_ready low exactly 4 cycles per pulse.
- Write CTRL=0b111, VEL=0x0F0F, then frame pulses → x steps 128,143,…; crossing 368 clamps to 368 and direction flips; next frame 353. y clamps at 304.
- Direction −, x=5, dx=15 → x=0 with direction +; next frame x=15.
- POS_X=1000 written during a moving frame → next frame x=368 and no motion that frame; POS_Y unaffected.
- Write accepted in the same cycle as frame_start → applied in that frame. cfg_valid held during T+1..T+4 → not accepted until T+5.
- frame_start at T+2 → ignored and overrun=1. Reset at T+3 → outputs return to reset values; shadow writes are lost.
